countdown_timer: RTL and testbench

Loadable down-counter that complements the free-running up `counter`. It accepts a start value over a valid/ready load handshake and decrements while `enable` is high. On reaching zero it emits a one-cycle `done` pulse, then either stops or reloads. It sits beside `counter` in the timing utilities and drives timeouts, pulse spacing and periodic ticks for downstream blocks.

---
 rtl/countdown_pkg.sv | 6 +
 rtl/countdown_timer.sv | 73 +++++++
 tb/tb_countdown_timer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and constants for countdown_timer
// Contents: state_e (ST_IDLE, ST_RUN) and DEFAULT_NUM_BITS, the default count width
package countdown_pkg;
    typedef enum logic {ST_IDLE, ST_RUN} state_e;
    localparam int DEFAULT_NUM_BITS = 8;
endpackage

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-cycle done pulse and optional auto-reload
// Ports: clk, reset (sync, active-high), enable (decrement permit),
//        load_valid/load_ready/load_value (start-value handshake, accepted in IDLE),
//        auto_reload (restart from last load on expiry), cancel (abort without done),
//        count (remaining count), done (expiry pulse), busy (running)
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [NUM_BITS-1:0] load_value,
    input  logic                auto_reload,
    input  logic                cancel,
    output logic [NUM_BITS-1:0] count,
    output logic                done,
    output logic                busy
);
    state_e              state, state_n;
    logic [NUM_BITS-1:0] count_n, reload_reg, reload_n;
    logic                done_n;

    assign load_ready = (state == ST_IDLE);
    assign busy       = (state == ST_RUN);

    // count is always >= 1 in RUN, so expiry at 1 means it can never underflow
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_reg;
        done_n   = 1'b0;
        if (state == ST_IDLE) begin
            if (load_valid) begin
                count_n = load_value;
                if (load_value != '0) begin
                    reload_n = load_value;
                    state_n  = ST_RUN;
                end else begin
                    done_n = 1'b1;
                end
            end
        end else if (cancel) begin
            count_n = '0;
            state_n = ST_IDLE;
        end else if (enable) begin
            if (count == NUM_BITS'(1)) begin
                done_n  = 1'b1;
                count_n = auto_reload ? reload_reg : '0;
                state_n = auto_reload ? ST_RUN : ST_IDLE;
            end else begin
                count_n = count - NUM_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            reload_reg <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload_reg <= reload_n;
            done       <= done_n;
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: self-checking bench for countdown_timer
// Directed scenarios plus randomized runs checked against an arithmetic model
// (expected count derived from the number of enabled cycles since the load).
module tb_countdown_timer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_value = '0;
    logic       auto_reload = 1'b0;
    logic       cancel = 1'b0;
    logic [7:0] count;
    logic       done;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;

    countdown_timer #(.NUM_BITS(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
        .load_ready(load_ready), .load_value(load_value), .auto_reload(auto_reload),
        .cancel(cancel), .count(count), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // advance one edge; outputs are then observed 1 time unit after it
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int n);
        load_valid = 1'b1;
        load_value = 8'(n);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        load_valid = 1'b1;
        load_value = 8'd9;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cancel = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (count !== 8'd0 || done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: count=%0d done=%0b busy=%0b, want 0/0/0", count, done, busy);
            end
        end
        reset = 1'b0;
        load_valid = 1'b0;
        cancel = 1'b0;
        enable = 1'b0;
        tick();
        n_checks++;
        if (load_ready !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_release: load_ready=%0b busy=%0b count=%0d, want 1/0/0", load_ready, busy, count);
        end
    endtask

    task automatic test_basic;
        enable = 1'b1;
        auto_reload = 1'b0;
        do_load(5);
        n_checks++;
        if (count !== 8'd5 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_load: count=%0d busy=%0b done=%0b, want 5/1/0", count, busy, done);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++;
            if (count !== 8'(5 - i) || done !== (i == 5) || busy !== (i < 5)) begin
                n_fail++;
                $display("FAIL basic_step%0d: count=%0d done=%0b busy=%0b, want %0d/%0b/%0b",
                         i, count, done, busy, 5 - i, i == 5, i < 5);
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_width: done=%0b, want 0", done);
        end
    endtask

    task automatic test_pause;
        int done_at = -1;
        enable = 1'b1;
        do_load(10);
        for (int i = 1; i <= 16; i++) begin
            enable = !(i >= 5 && i <= 7);
            tick();
            if (done && done_at < 0) done_at = i;
            if (i >= 4 && i <= 7) begin
                n_checks++;
                if (count !== 8'd6) begin
                    n_fail++;
                    $display("FAIL pause_hold%0d: count=%0d, want 6", i, count);
                end
            end
        end
        enable = 1'b1;
        n_checks++;
        if (done_at != 13) begin
            n_fail++;
            $display("FAIL pause_done: done at edge %0d, want 13", done_at);
        end
    endtask

    task automatic test_auto_reload;
        int seq[6] = '{2, 1, 3, 2, 1, 3};
        enable = 1'b1;
        auto_reload = 1'b1;
        do_load(3);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (count !== 8'(seq[i]) || done !== (seq[i] == 3) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL reload_step%0d: count=%0d done=%0b busy=%0b, want %0d/%0b/1",
                         i, count, done, busy, seq[i], seq[i] == 3);
            end
        end
        auto_reload = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (count !== 8'(2 - i) || done !== (i == 2) || busy !== (i < 2)) begin
                n_fail++;
                $display("FAIL reload_stop%0d: count=%0d done=%0b busy=%0b, want %0d/%0b/%0b",
                         i, count, done, busy, 2 - i, i == 2, i < 2);
            end
        end
    endtask

    task automatic test_boundary;
        int bad = 0;
        enable = 1'b1;
        auto_reload = 1'b0;
        tick();
        do_load(0);
        n_checks++;
        if (count !== 8'd0 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_zero: count=%0d done=%0b busy=%0b, want 0/1/0", count, done, busy);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_zero_after: done=%0b busy=%0b, want 0/0", done, busy);
        end
        do_load(255);
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i <= 255 && (count !== 8'(255 - i) || done !== (i == 255))) bad++;
            if (i == 256 && (count !== 8'd0 || done !== 1'b0 || busy !== 1'b0)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL load_255: %0d bad cycles, want 0", bad);
        end
        do_load(20);
        tick();
        tick();
        load_valid = 1'b1;
        load_value = 8'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (load_ready !== 1'b0 || count !== 8'(17 - i)) begin
                n_fail++;
                $display("FAIL load_in_run%0d: load_ready=%0b count=%0d, want 0/%0d", i, load_ready, count, 17 - i);
            end
        end
        load_valid = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic test_cancel;
        enable = 1'b1;
        auto_reload = 1'b0;
        for (int mode = 0; mode < 2; mode++) begin
            do_load(8);
            for (int i = 0; i < 4; i++) tick();
            if (mode == 0) cancel = 1'b1; else reset = 1'b1;
            tick();
            cancel = 1'b0;
            reset = 1'b0;
            n_checks++;
            if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_mode%0d: count=%0d busy=%0b done=%0b, want 0/0/0", mode, count, busy, done);
            end
            tick();
            n_checks++;
            if (done !== 1'b0 || load_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_after%0d: done=%0b load_ready=%0b, want 0/1", mode, done, load_ready);
            end
        end
        do_load(2);
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_checks++;
        if (done !== 1'b0 || count !== 8'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_at_expiry: done=%0b count=%0d busy=%0b, want 0/0/0", done, count, busy);
        end
    endtask

    task automatic test_back_to_back;
        enable = 1'b1;
        auto_reload = 1'b0;
        do_load(2);
        tick();
        tick();
        n_checks++;
        if (done !== 1'b1 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: done=%0b load_ready=%0b, want 1/1", done, load_ready);
        end
        do_load(4);
        n_checks++;
        if (count !== 8'd4 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_reload: count=%0d busy=%0b done=%0b, want 4/1/0", count, busy, done);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    // model: after a load of n, the count depends only on e, the number of enabled edges since
    task automatic test_random;
        for (int r = 0; r < 25; r++) begin
            int n = $urandom_range(1, 12);
            bit ar = 1'($urandom_range(0, 1));
            int len = $urandom_range(5, 40);
            int e = 0;
            bit fin = 1'b0;
            auto_reload = ar;
            do_load(n);
            for (int c = 0; c < len && !fin; c++) begin
                bit en = ($urandom_range(0, 9) < 7);
                int exp_count;
                bit exp_done, exp_busy;
                enable = en;
                load_valid = 1'($urandom_range(0, 1));
                load_value = 8'($urandom);
                tick();
                if (en) e++;
                exp_done = en && (e % n == 0);
                exp_count = ar ? n - (e % n) : n - e;
                exp_busy = ar || (e < n);
                n_checks++;
                if (count !== 8'(exp_count) || done !== exp_done || busy !== exp_busy) begin
                    n_fail++;
                    $display("FAIL random_r%0d_c%0d: count=%0d done=%0b busy=%0b, want %0d/%0b/%0b (n=%0d ar=%0b)",
                             r, c, count, done, busy, exp_count, exp_done, exp_busy, n, ar);
                end
                if (!ar && e == n) fin = 1'b1;
            end
            load_valid = 1'b0;
            enable = 1'b0;
            if (!fin) begin
                cancel = 1'b1;
                tick();
                cancel = 1'b0;
                n_checks++;
                if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_cancel%0d: count=%0d busy=%0b done=%0b, want 0/0/0", r, count, busy, done);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_auto_reload();
        test_boundary();
        test_cancel();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
